// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - MIPS E-stage multiply/divide unit with HI/LO registers and stall request
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        hilo_sel,
    input  logic        d_allmudi,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data,
    output logic        md_stall
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [31:0]        hi_n, lo_n;
    logic [31:0]        res_hi, res_lo, res_hi_n, res_lo_n;

    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic [31:0]        a_mag, b_mag, b_safe, bu_safe;
    logic [31:0]        sq_mag, sr_mag, s_quot, s_rem;
    logic [31:0]        u_quot, u_rem;
    logic [31:0]        calc_hi, calc_lo;

    // Arithmetic for the operation presented in E; the signed divide works on
    // magnitudes so 0x80000000 / -1 wraps to 0x80000000 with a zero remainder.
    always_comb begin
        sprod   = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
        uprod   = {32'd0, rs_val} * {32'd0, rt_val};
        a_mag   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
        b_mag   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
        b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
        bu_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
        sq_mag  = a_mag / b_safe;
        sr_mag  = a_mag % b_safe;
        s_quot  = (rs_val[31] ^ rt_val[31]) ? (32'd0 - sq_mag) : sq_mag;
        s_rem   = rs_val[31] ? (32'd0 - sr_mag) : sr_mag;
        u_quot  = rs_val / bu_safe;
        u_rem   = rs_val % bu_safe;
        calc_hi = hi;
        calc_lo = lo;
        case (md_op[1:0])
            2'd0: begin calc_hi = sprod[63:32]; calc_lo = sprod[31:0]; end
            2'd1: begin calc_hi = uprod[63:32]; calc_lo = uprod[31:0]; end
            default: begin
                // Divide by zero keeps the current HI/LO as the committed result.
                if (rt_val != 32'd0) begin
                    calc_hi = md_op[0] ? u_rem  : s_rem;
                    calc_lo = md_op[0] ? u_quot : s_quot;
                end
            end
        endcase
    end

    // Next-state logic: launch, count down, commit, and single-cycle HI/LO writes.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi;
        lo_n     = lo;
        res_hi_n = res_hi;
        res_lo_n = res_lo;
        case (state)
            IDLE: begin
                if (start && !md_op[2]) begin
                    res_hi_n = calc_hi;
                    res_lo_n = calc_lo;
                    cnt_n    = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_n  = BUSY;
                end else if (md_we && !start) begin
                    if (md_op == 3'd4) hi_n = rs_val;
                    if (md_op == 3'd5) lo_n = rs_val;
                end
            end
            BUSY: begin
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    hi_n    = res_hi;
                    lo_n    = res_lo;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi     <= hi_n;
            lo     <= lo_n;
            res_hi <= res_hi_n;
            res_lo <= res_lo_n;
        end
    end

    assign busy     = (state == BUSY);
    assign rd_data  = hilo_sel ? hi : lo;
    assign md_stall = d_allmudi & (start | busy);

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit against an arithmetic reference model
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd7;
    logic        md_we = 1'b0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        hilo_sel = 1'b0;
    logic        d_allmudi = 1'b0;
    logic        busy;
    logic [31:0] hi, lo, rd_data;
    logic        md_stall;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu_unit dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op), .md_we(md_we),
        .rs_val(rs_val), .rt_val(rt_val), .hilo_sel(hilo_sel), .d_allmudi(d_allmudi),
        .busy(busy), .hi(hi), .lo(lo), .rd_data(rd_data), .md_stall(md_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: HI/LO after an operation, from plain integer arithmetic.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint p;
        logic [63:0] up;
        ia = a;
        ib = b;
        case (op)
            3'd0: begin p = longint'(ia) * longint'(ib); m_hi = p[63:32]; m_lo = p[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b}; m_hi = up[63:32]; m_lo = up[31:0]; end
            3'd2: if (b != 0) begin
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin m_lo = a; m_hi = 32'd0; end
                else begin m_lo = ia / ib; m_hi = ia % ib; end
            end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            default: ;
        endcase
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_hi"}, {32'd0, hi}, {32'd0, m_hi});
        chk({tag, "_lo"}, {32'd0, lo}, {32'd0, m_lo});
    endtask

    // mthi (op 4) / mtlo (op 5) single-cycle write.
    task automatic move_to(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        md_we = 1'b1; md_op = op; rs_val = v;
        @(negedge clk);
        md_we = 1'b0; md_op = 3'd7;
        if (op == 3'd4) m_hi = v; else m_lo = v;
        chk("mt_busy", {63'd0, busy}, 64'd0);
        hilo_sel = (op == 3'd4);
        #1 chk("mt_rd", {32'd0, rd_data}, {32'd0, v});
    endtask

    // inject: 0 none, 1 mtlo at busy cycle 2, 2 second start at busy cycle 3.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic stall_d, input int inject,
                          input logic we_too);
        int n;
        int exp_n;
        logic [31:0] old_hi, old_lo;
        exp_n  = op[1] ? 10 : 5;
        old_hi = m_hi;
        old_lo = m_lo;
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b; d_allmudi = stall_d; md_we = we_too;
        #1 chk({tag, "_stall0"}, {63'd0, md_stall}, {63'd0, stall_d});
        model_op(op, a, b);
        @(negedge clk);
        start = 1'b0; md_we = 1'b0;
        n = 0;
        while (busy && n < 30) begin
            hilo_sel = n[0];
            #1;
            chk({tag, "_hold_hi"}, {32'd0, hi}, {32'd0, old_hi});
            chk({tag, "_hold_lo"}, {32'd0, lo}, {32'd0, old_lo});
            chk({tag, "_rd"}, {32'd0, rd_data}, {32'd0, n[0] ? old_hi : old_lo});
            chk({tag, "_stall"}, {63'd0, md_stall}, {63'd0, stall_d});
            if (inject == 1 && n == 1) begin
                md_we = 1'b1; md_op = 3'd5; rs_val = 32'h55;
            end else if (inject == 2 && n == 2) begin
                start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
            end else begin
                md_we = 1'b0; start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        md_we = 1'b0; start = 1'b0; md_op = 3'd7;
        chk({tag, "_cycles"}, 64'(n), 64'(exp_n));
        #1 chk({tag, "_stall_end"}, {63'd0, md_stall}, 64'd0);
        check_regs(tag);
        d_allmudi = 1'b0;
    endtask

    initial begin
        // Reset held low with stimulus active.
        start = 1'b1; md_we = 1'b1; md_op = 3'd4; rs_val = 32'hDEADBEEF; rt_val = 32'd3;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        start = 1'b0; md_we = 1'b0; md_op = 3'd7;
        reset = 1'b1;
        @(negedge clk);
        check_regs("post_rst");

        // Directed arithmetic.
        run_op("mult", 3'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 0, 1'b0);
        chk("mult_hi_c", {32'd0, hi}, 64'hFFFFFFFF);
        chk("mult_lo_c", {32'd0, lo}, 64'hFFFFFFFA);
        run_op("multu", 3'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 0, 1'b0);
        chk("multu_hi_c", {32'd0, hi}, 64'h2);
        chk("multu_lo_c", {32'd0, lo}, 64'hFFFFFFFA);
        run_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 0, 1'b0);
        chk("div_hi_c", {32'd0, hi}, 64'hFFFFFFFF);
        chk("div_lo_c", {32'd0, lo}, 64'hFFFFFFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 1'b0, 0, 1'b0);
        chk("divu_hi_c", {32'd0, hi}, 64'd1);
        chk("divu_lo_c", {32'd0, lo}, 64'd3);
        run_op("divmin", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
        chk("divmin_hi_c", {32'd0, hi}, 64'd0);
        chk("divmin_lo_c", {32'd0, lo}, 64'h80000000);

        // Divide by zero keeps preloaded HI/LO.
        move_to(3'd4, 32'h11);
        move_to(3'd5, 32'h22);
        run_op("div0", 3'd2, 32'd1234, 32'd0, 1'b1, 0, 1'b0);
        chk("div0_hi_c", {32'd0, hi}, 64'h11);
        chk("div0_lo_c", {32'd0, lo}, 64'h22);

        // Illegal overlaps.
        run_op("mtlo_busy", 3'd0, 32'd6, 32'd7, 1'b1, 1, 1'b0);
        run_op("restart", 3'd2, 32'd1000, 32'd3, 1'b1, 2, 1'b0);
        run_op("restart_m", 3'd1, 32'd9, 32'd9, 1'b0, 2, 1'b0);
        run_op("start_we", 3'd1, 32'h10000, 32'h10000, 1'b1, 0, 1'b1);

        // Randomized operations and moves.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic [2:0]  op;
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(1, 9);
            op = 3'($urandom_range(0, 5));
            if (op[2]) move_to(op, a);
            else run_op("rand", op, a, b, 1'($urandom_range(0, 1)), 0, 1'b0);
        end

        // Asynchronous reset in the middle of a divide.
        move_to(3'd4, 32'hAA);
        move_to(3'd5, 32'hBB);
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; rs_val = 32'd50; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_hi", {32'd0, hi}, 64'd0);
        chk("arst_lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        chk("arst_after_busy", {63'd0, busy}, 64'd0);
        check_regs("arst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
